// File: rtl/wb_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_queue_if
//  Description : Bundle for the write-back queue: two producer handshakes
//                (A = ALU, B = load unit), the register file write port,
//                the pending-register vector and two forwarding lookups.
//                master : producers / decode side (drives valids, lookups)
//                slave  : the queue itself (drives readies, rf port, hits)
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic                       a_valid;
    logic                       a_ready;
    logic [ADDR_W-1:0]          a_addr;
    logic [DATA_W-1:0]          a_data;

    logic                       b_valid;
    logic                       b_ready;
    logic [ADDR_W-1:0]          b_addr;
    logic [DATA_W-1:0]          b_data;

    logic                       rf_we;
    logic [ADDR_W-1:0]          rf_wr;
    logic [DATA_W-1:0]          rf_wd;

    logic [(1<<ADDR_W)-1:0]     pending;

    logic [ADDR_W-1:0]          q1_addr;
    logic                       q1_hit;
    logic [DATA_W-1:0]          q1_data;
    logic [ADDR_W-1:0]          q2_addr;
    logic                       q2_hit;
    logic [DATA_W-1:0]          q2_data;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output q1_addr, q2_addr,
        input  a_ready, b_ready,
        input  rf_we, rf_wr, rf_wd,
        input  pending,
        input  q1_hit, q1_data, q2_hit, q2_data
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  q1_addr, q2_addr,
        output a_ready, b_ready,
        output rf_we, rf_wr, rf_wd,
        output pending,
        output q1_hit, q1_data, q2_hit, q2_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_queue
//  Description : In-order write-back buffer in front of the register file.
//                Accepts up to two results per cycle (A older than B),
//                drains one entry per cycle onto the rf write port, and
//                exposes pending bits plus two youngest-match lookups.
//  Ports       : clock, reset (sync, active-high)
//                bus (wb_queue_if.slave) - producer handshakes, rf port,
//                pending vector, forwarding lookups q1/q2
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic        clock,
    input  logic        reset,
    wb_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];

    logic [CNT_W-1:0]   w_free;
    logic               w_a_ready;
    logic               w_b_ready;
    logic               w_push_a;
    logic               w_push_b;
    logic               w_pop;
    logic               w_empty;
    logic [PTR_W-1:0]   w_b_slot;
    logic [NREG-1:0]    w_pending;
    logic               w_q1_hit;
    logic [DATA_W-1:0]  w_q1_data;
    logic               w_q2_hit;
    logic [DATA_W-1:0]  w_q2_data;

    // Space is judged on the count at the start of the cycle; the drain
    // happening this same cycle does not free a slot until the next one.
    assign w_free    = C_DEPTH - r_count;
    assign w_empty   = (r_count == '0);
    assign w_a_ready = !reset && (w_free >= CNT_W'(1));
    // A has priority: B only gets the last free slot when A is idle.
    assign w_b_ready = !reset && ((w_free >= CNT_W'(2)) ||
                                  ((w_free >= CNT_W'(1)) && !bus.a_valid));
    assign w_push_a  = bus.a_valid && w_a_ready;
    assign w_push_b  = bus.b_valid && w_b_ready;
    assign w_pop     = !reset && !w_empty;
    // B lands behind A when both transfer together.
    assign w_b_slot  = w_push_a ? r_tail + PTR_W'(1) : r_tail;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_push_a) + PTR_W'(w_push_b);
            r_count <= r_count + CNT_W'(w_push_a) + CNT_W'(w_push_b)
                       - CNT_W'(w_pop);
        end
    end

    // Storage is never cleared; validity is tracked purely by head/count.
    always_ff @(posedge clock) begin
        if (w_push_a) begin
            r_addr[r_tail] <= bus.a_addr;
            r_data[r_tail] <= bus.a_data;
        end
        if (w_push_b) begin
            r_addr[w_b_slot] <= bus.b_addr;
            r_data[w_b_slot] <= bus.b_data;
        end
    end

    // Walk valid entries oldest to youngest so the last match wins,
    // which keeps age order correct across the pointer wrap.
    always_comb begin
        w_pending = '0;
        w_q1_hit  = 1'b0;
        w_q1_data = '0;
        w_q2_hit  = 1'b0;
        w_q2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < r_count) begin
                w_pending[r_addr[r_head + PTR_W'(k)]] = 1'b1;
                if (r_addr[r_head + PTR_W'(k)] == bus.q1_addr) begin
                    w_q1_hit  = 1'b1;
                    w_q1_data = r_data[r_head + PTR_W'(k)];
                end
                if (r_addr[r_head + PTR_W'(k)] == bus.q2_addr) begin
                    w_q2_hit  = 1'b1;
                    w_q2_data = r_data[r_head + PTR_W'(k)];
                end
            end
        end
    end

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;
    assign bus.rf_we   = w_pop;
    assign bus.rf_wr   = w_empty ? '0 : r_addr[r_head];
    assign bus.rf_wd   = w_empty ? '0 : r_data[r_head];
    assign bus.pending = w_pending;
    assign bus.q1_hit  = w_q1_hit;
    assign bus.q1_data = w_q1_data;
    assign bus.q2_hit  = w_q2_hit;
    assign bus.q2_data = w_q2_data;

endmodule
`default_nettype wire

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back buffer directly upstream of the 8x16 register file. Accepts results from two producers: the ALU (port A) and the load unit (port B).
- Queues results in a small in-order FIFO and drains one entry per cycle onto the register file write port (WR/WE/WD).
- Provides per-register pending bits and two forwarding lookups. Decode can bypass results that are queued but not yet written.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- DATA_W, 16, result width; matches register width
- ADDR_W, 3, register address width (8 registers)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- a_valid  in  1  ALU result valid
- a_ready  out  1  port A accept
- a_addr  in  ADDR_W  ALU destination register
- a_data  in  DATA_W  ALU result
- b_valid  in  1  load result valid
- b_ready  out  1  port B accept
- b_addr  in  ADDR_W  load destination register
- b_data  in  DATA_W  load data
- rf_we  out  1  register file write enable
- rf_wr  out  ADDR_W  register file write address
- rf_wd  out  DATA_W  register file write data
- pending  out  8  bit r = 1 when any queued entry targets register r
- q1_addr  in  ADDR_W  lookup 1 address
- q1_hit  out  1  lookup 1 match
- q1_data  out  DATA_W  lookup 1 data
- q2_addr  in  ADDR_W  lookup 2 address
- q2_hit  out  1  lookup 2 match
- q2_data  out  DATA_W  lookup 2 data

Behaviour:
- Storage and reset:
  - Circular FIFO with head/tail pointers (log2 DEPTH bits, natural wrap) and count 0..DEPTH.
  - Reset sets count, head and tail to 0. Storage contents are not cleared.
- Free-slot rule: free = DEPTH - count, taken from the registered count at the start of the cycle. A pop in the same cycle does not add space.
- Ready rules:
  - a_ready = (free >= 1).
  - b_ready = (free >= 2) or (free >= 1 and !a_valid). Port A has priority.
  - Both ready signals are 0 while reset is high.
- Push:
  - A transfer occurs on a posedge with valid and ready both high.
  - If A and B transfer in the same cycle, A is enqueued first (older), then B. Tail advances by 0, 1 or 2.
  - A valid that is not accepted causes no state change. The producer holds its data.
- Drain:
  - rf_we = (count != 0) and !reset.
  - rf_wr and rf_wd show the head entry when count != 0, else 0.
  - On every posedge with count != 0 and !reset, head advances by 1 (the register file captures at that same edge).
  - One write per cycle. No backpressure from the register file.
- Latency: for a push at edge N into an empty queue, rf_we is high in cycle N..N+1. The register file holds the value after edge N+1.
- Count update: count_next = count + pushes - pop, where pop is 0 or 1 and pushes is 0, 1 or 2. Count never exceeds DEPTH because of the ready rules.
- Ordering:
  - Entries are written strictly in enqueue order.
  - Two queued writes to the same register are both performed, in order, so the last write wins.
- pending: combinational OR over valid entries, including the head entry being written this cycle. All bits are 0 when empty.
- Lookups (q1, q2 are independent and identical):
  - Search valid entries, including the head.
  - The youngest matching entry (closest to tail) supplies qN_data and sets qN_hit = 1.
  - With no match, qN_hit = 0 and qN_data = 0.
  - Entries pushed in the current cycle are not visible until after the edge.
- Register 0: no special case. All 8 registers are writable and forwardable.
- Reset mid-operation:
  - All queued entries are discarded and no further register file writes occur from them.
  - rf_we is 0 during the reset cycle(s).
  - The first cycle after reset deasserts behaves as an empty queue.
- Full queue (count == DEPTH): a_ready = b_ready = 0. The drain continues, and ready rises the cycle after count drops.
- Wrap-around: pointers wrap modulo DEPTH. Lookup age ordering must be correct across the wrap point.

Test Plan:
- Single push: reset, then A pushes r3 = 0x1234 at edge 1.
  - Cycle 1: rf_we = 1, rf_wr = 3, rf_wd = 0x1234, pending = 8'b0000_1000, q1(addr 3) hit with 0x1234.
  - Cycle 2: rf_we = 0, pending = 0.
- Dual push ordering: A (r2 = 0x00AA) and B (r2 = 0x00BB) are both valid on an empty queue.
  - Both are accepted in one cycle.
  - Writes appear in consecutive cycles as 0x00AA then 0x00BB.
  - q1(addr 2) returns 0x00BB while both are queued, then 0x00BB while only B remains.
- Fill and backpressure: A pushes every cycle while the drain runs.
  - Steady count stays at 1.
  - Then with A and B valid every cycle, the queue reaches DEPTH = 4 with a_ready = b_ready = 0.
  - b_ready is 0 whenever free == 1 and a_valid = 1.
  - No entry is lost or duplicated; the sequence of register file writes is checked against a scoreboard model.
- Wrap-around forwarding: push 6 entries to r5 with values 1..6, staggered so that the tail wraps.
  - q2(addr 5) always returns the youngest queued value.
  - The final register file value is 6.
- Reset mid-operation: queue 3 entries, then assert reset for 1 cycle.
  - rf_we = 0 during reset.
  - After reset: pending = 0, q1_hit = 0, a_ready = 1, and no stale writes occur.
- Miss lookup: queue r1 only; q1(addr 7) returns hit = 0 and data = 0x0000.
